// File: rtl/anpc_pkg.sv
// Shared definitions for the 3L-ANPC leg: steady switch patterns, state codes,
// level codes and monitor fault codes.
package anpc_pkg;

   typedef enum logic [2:0] {
      ST_P    = 3'd0,
      ST_Z_U2 = 3'd1,
      ST_Z_U1 = 3'd2,
      ST_Z_L1 = 3'd3,
      ST_Z_L2 = 3'd4,
      ST_N    = 3'd5
   } anpc_state_e;

   typedef enum logic [1:0] {
      LVL_ZERO = 2'd0,
      LVL_P    = 2'd1,
      LVL_N    = 2'd2
   } anpc_level_e;

   typedef enum logic [1:0] {
      FC_NONE  = 2'd0,
      FC_MULTI = 2'd1,
      FC_DWELL = 2'd2,
      FC_STUCK = 2'd3
   } fault_code_e;

   localparam logic [5:0] PAT_P    = 6'b110_001;
   localparam logic [5:0] PAT_Z_U2 = 6'b010_010;
   localparam logic [5:0] PAT_Z_U1 = 6'b010_110;
   localparam logic [5:0] PAT_Z_L1 = 6'b101_001;
   localparam logic [5:0] PAT_Z_L2 = 6'b001_001;
   localparam logic [5:0] PAT_N    = 6'b001_110;

   function automatic logic [2:0] popcount6(input logic [5:0] w);
      logic [2:0] sum;
      sum = 3'd0;
      for (int i = 0; i < 6; i++) sum = sum + {2'b00, w[i]};
      return sum;
   endfunction

endpackage

// File: rtl/anpc_pattern_decode.sv
// Combinational decode of a 6-bit switch word into steady flag, leg state and
// output level. Non-steady words report steady=0 with don't-care state/level.
module anpc_pattern_decode
   import anpc_pkg::*;
(
   input  logic [5:0] word_i,
   output logic       steady_o,
   output logic [2:0] state_o,
   output logic [1:0] level_o
);

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis would infer a latch to hold it.
   always_comb begin
      steady_o = 1'b1;
      state_o  = ST_Z_U2;
      level_o  = LVL_ZERO;
      case (word_i)
         PAT_P: begin
            state_o = ST_P;
            level_o = LVL_P;
         end
         PAT_Z_U2: state_o = ST_Z_U2;
         PAT_Z_U1: state_o = ST_Z_U1;
         PAT_Z_L1: state_o = ST_Z_L1;
         PAT_Z_L2: state_o = ST_Z_L2;
         PAT_N: begin
            state_o = ST_N;
            level_o = LVL_N;
         end
         default: steady_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/anpc_gate_monitor.sv
// Receiver-side monitor for a 3L-ANPC leg switch word: decodes the steady
// state/level and latches the first commutation-legality fault.
module anpc_gate_monitor
   import anpc_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic [5:0]    s_in,
   input  logic [CW-1:0] t_dwell,
   input  logic [CW-1:0] t_stuck,
   input  logic          clr_fault,
   output logic [2:0]    state_o,
   output logic [1:0]    level_o,
   output logic          steady_o,
   output logic          fault_o,
   output logic [1:0]    fault_code_o,
   output logic [15:0]   step_cnt_o
);

   typedef enum logic [1:0] {
      FSM_STEADY  = 2'd0,
      FSM_TRANSIT = 2'd1,
      FSM_FAULT   = 2'd2
   } mon_fsm_e;

   mon_fsm_e      fsm_q, fsm_d;
   logic [5:0]    s_q, s_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic [2:0]    state_q, state_d;
   logic [1:0]    level_q, level_d;
   logic          steady_q, steady_d;
   fault_code_e   code_q, code_d;
   logic [15:0]   step_q, step_d;

   logic          in_steady;
   logic [2:0]    in_state;
   logic [1:0]    in_level;
   logic [2:0]    n_diff;
   logic [CW:0]   stuck_age;
   fault_code_e   cause;

   anpc_pattern_decode u_decode (
      .word_i   (s_in),
      .steady_o (in_steady),
      .state_o  (in_state),
      .level_o  (in_level)
   );

   assign n_diff = popcount6(s_in ^ s_q);

   always_comb begin
      s_d       = s_q;
      dwell_d   = dwell_q;
      state_d   = state_q;
      level_d   = level_q;
      steady_d  = steady_q;
      step_d    = step_q;
      code_d    = code_q;
      fsm_d     = fsm_q;
      cause     = FC_NONE;
      stuck_age = '0;

      if (ce) begin
         s_d      = s_in;
         steady_d = in_steady;
         if (n_diff == 3'd0) begin
            if (dwell_q != '1) dwell_d = dwell_q + 1'b1;
         end else begin
            dwell_d = '0;
         end

         // Age of the word just sampled, counting this sample; one extra bit so
         // a saturated dwell counter still compares correctly.
         stuck_age = {1'b0, dwell_d} + {{CW{1'b0}}, 1'b1};

         if (n_diff >= 3'd2)
            cause = FC_MULTI;
         else if (n_diff == 3'd1 && t_dwell != '0 && dwell_q < t_dwell)
            cause = FC_DWELL;
         else if (!in_steady && t_stuck != '0 && stuck_age >= {1'b0, t_stuck})
            cause = FC_STUCK;

         // A faulting sample never becomes the reported steady state.
         if (cause == FC_NONE && in_steady) begin
            state_d = in_state;
            level_d = in_level;
         end
         if (cause == FC_NONE && n_diff == 3'd1 && fsm_q != FSM_FAULT)
            step_d = step_q + 16'd1;
      end

      if (cause != FC_NONE) begin
         fsm_d = FSM_FAULT;
         if (fsm_q != FSM_FAULT || clr_fault) code_d = cause;
      end else begin
         case (fsm_q)
            FSM_FAULT: begin
               if (clr_fault) begin
                  fsm_d  = steady_d ? FSM_STEADY : FSM_TRANSIT;
                  code_d = FC_NONE;
               end
            end
            default: begin
               if (ce) fsm_d = in_steady ? FSM_STEADY : FSM_TRANSIT;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q    <= FSM_STEADY;
         s_q      <= PAT_Z_U2;
         dwell_q  <= '1;
         state_q  <= ST_Z_U2;
         level_q  <= LVL_ZERO;
         steady_q <= 1'b1;
         code_q   <= FC_NONE;
         step_q   <= '0;
      end else begin
         fsm_q    <= fsm_d;
         s_q      <= s_d;
         dwell_q  <= dwell_d;
         state_q  <= state_d;
         level_q  <= level_d;
         steady_q <= steady_d;
         code_q   <= code_d;
         step_q   <= step_d;
      end
   end

   assign state_o      = state_q;
   assign level_o      = level_q;
   assign steady_o     = steady_q;
   assign fault_o      = (fsm_q == FSM_FAULT);
   assign fault_code_o = code_q;
   assign step_cnt_o   = step_q;

endmodule

// File: tb/tb_anpc_gate_monitor.sv
// Directed bench for anpc_gate_monitor: a sample-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_anpc_gate_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic [5:0]  s_in = 6'b010_010;
   logic [7:0]  t_dwell = 8'd0;
   logic [7:0]  t_stuck = 8'd0;
   logic        clr_fault = 1'b0;
   logic [2:0]  state_o;
   logic [1:0]  level_o;
   logic        steady_o;
   logic        fault_o;
   logic [1:0]  fault_code_o;
   logic [15:0] step_cnt_o;

   int n_chk = 0;
   int n_err = 0;

   anpc_gate_monitor #(.CW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .s_in         (s_in),
      .t_dwell      (t_dwell),
      .t_stuck      (t_stuck),
      .clr_fault    (clr_fault),
      .state_o      (state_o),
      .level_o      (level_o),
      .steady_o     (steady_o),
      .fault_o      (fault_o),
      .fault_code_o (fault_code_o),
      .step_cnt_o   (step_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (one step per sample) ----------------
   logic [5:0] steady_tab [6] = '{6'b110_001, 6'b010_010, 6'b010_110,
                                  6'b101_001, 6'b001_001, 6'b001_110};

   function automatic int lookup(input logic [5:0] w);
      for (int i = 0; i < 6; i++) if (steady_tab[i] == w) return i;
      return -1;
   endfunction

   bit         m_armed = 1'b0;
   logic [5:0] m_word;
   int         m_run;      // samples the current word has been seen, reset counts as long-held
   int         m_state, m_level, m_code, m_steps;
   bit         m_fault, m_steady;

   always @(posedge clk) begin
      int nb, dw, new_run, idx, cause;
      bit was_fault;
      if (rst) begin
         m_armed = 1'b1;
         m_word = 6'b010_010; m_run = 256;
         m_state = 1; m_level = 0; m_steady = 1'b1;
         m_fault = 1'b0; m_code = 0; m_steps = 0;
      end else if (m_armed) begin
         was_fault = m_fault;
         if (ce) begin
            nb      = $countones(s_in ^ m_word);
            dw      = (m_run - 1 > 255) ? 255 : m_run - 1;
            new_run = (nb == 0) ? m_run + 1 : 1;
            idx     = lookup(s_in);
            cause   = 0;
            if (nb >= 2) cause = 1;
            else if (nb == 1 && t_dwell != 0 && dw < int'(t_dwell)) cause = 2;
            else if (idx < 0 && t_stuck != 0 && new_run >= int'(t_stuck)) cause = 3;

            if (cause != 0) begin
               if (!was_fault || clr_fault) m_code = cause;
               m_fault = 1'b1;
            end else if (clr_fault) begin
               m_fault = 1'b0; m_code = 0;
            end
            if (nb == 1 && cause == 0 && !was_fault) m_steps = (m_steps + 1) % 65536;
            if (idx >= 0 && cause == 0) begin
               m_state = idx;
               m_level = (idx == 0) ? 1 : (idx == 5) ? 2 : 0;
            end
            m_steady = (idx >= 0);
            m_word   = s_in;
            m_run    = new_run;
         end else if (clr_fault) begin
            m_fault = 1'b0; m_code = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_armed) begin
         check("state_o",      32'(state_o),      32'(m_state));
         check("level_o",      32'(level_o),      32'(m_level));
         check("steady_o",     32'(steady_o),     32'(m_steady));
         check("fault_o",      32'(fault_o),      32'(m_fault));
         check("fault_code_o", 32'(fault_code_o), 32'(m_code));
         check("step_cnt_o",   32'(step_cnt_o),   32'(m_steps));
      end
   end

   // ---------------- stimulus ----------------
   task automatic smp(input logic [5:0] w, input logic c, input logic cl);
      @(negedge clk);
      rst = 1'b0; s_in = w; ce = c; clr_fault = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [5:0] w, input int n);
      repeat (n) smp(w, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; ce = 1'b0; clr_fault = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_reset_values(input string tag);
      check({tag, " state"},  32'(state_o),      32'd1);
      check({tag, " level"},  32'(level_o),      32'd0);
      check({tag, " steady"}, 32'(steady_o),     32'd1);
      check({tag, " fault"},  32'(fault_o),      32'd0);
      check({tag, " code"},   32'(fault_code_o), 32'd0);
      check({tag, " steps"},  32'(step_cnt_o),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      do_reset();
      expect_reset_values("reset");

      // Legal walk Z_U2 -> P, samples 10 apart, dwell limit 4.
      t_dwell = 8'd4; t_stuck = 8'd0;
      smp(6'b010_000, 1'b1, 1'b0);
      check("walk steady drop", 32'(steady_o), 32'd0);
      check("walk hold state",  32'(state_o),  32'd1);
      hold(6'b010_000, 9);
      hold(6'b110_000, 10);
      hold(6'b110_001, 10);
      check("walk state P", 32'(state_o),    32'd0);
      check("walk level P", 32'(level_o),    32'd1);
      check("walk steps",   32'(step_cnt_o), 32'd3);
      check("walk no fault", 32'(fault_o),   32'd0);

      // P -> N in one sample.
      smp(6'b001_110, 1'b1, 1'b0);
      check("multi fault", 32'(fault_o),      32'd1);
      check("multi code",  32'(fault_code_o), 32'd1);
      check("multi state", 32'(state_o),      32'd0);

      // Clear while a steady word is held.
      smp(6'b001_110, 1'b1, 1'b1);
      check("clr steady fault", 32'(fault_o),      32'd0);
      check("clr steady code",  32'(fault_code_o), 32'd0);
      hold(6'b001_110, 10);

      // Dwell violation: two single-bit changes 3 samples apart.
      t_dwell = 8'd8;
      smp(6'b001_111, 1'b1, 1'b0);
      check("dwell first ok", 32'(fault_o), 32'd0);
      hold(6'b001_111, 2);
      smp(6'b001_110, 1'b1, 1'b0);
      check("dwell fault", 32'(fault_o),      32'd1);
      check("dwell code",  32'(fault_code_o), 32'd2);
      check("dwell steps", 32'(step_cnt_o),   32'd4);

      // Stuck in a transitional word.
      do_reset();
      t_dwell = 8'd0; t_stuck = 8'd20;
      hold(6'b011_010, 19);
      check("stuck 19 ok", 32'(fault_o), 32'd0);
      smp(6'b011_010, 1'b1, 1'b0);
      check("stuck fault", 32'(fault_o),      32'd1);
      check("stuck code",  32'(fault_code_o), 32'd3);
      smp(6'b100_101, 1'b1, 1'b0);
      check("first cause kept", 32'(fault_code_o), 32'd3);
      smp(6'b011_010, 1'b1, 1'b1);
      check("clr+multi fault", 32'(fault_o),      32'd1);
      check("clr+multi code",  32'(fault_code_o), 32'd1);

      // ce at 1:4 with legal steps.
      do_reset();
      t_stuck = 8'd0;
      repeat (3) smp(6'b010_110, 1'b0, 1'b0);
      check("ce0 holds steps", 32'(step_cnt_o), 32'd0);
      check("ce0 holds state", 32'(state_o),    32'd1);
      smp(6'b010_110, 1'b1, 1'b0);
      check("ce1 step Z_U1",  32'(state_o),    32'd2);
      check("ce1 step count", 32'(step_cnt_o), 32'd1);
      repeat (3) smp(6'b010_100, 1'b0, 1'b0);
      smp(6'b010_100, 1'b1, 1'b0);
      check("ce1 transit", 32'(steady_o),   32'd0);
      check("ce1 steps 2", 32'(step_cnt_o), 32'd2);

      // Clear honoured with ce=0.
      smp(6'b111_111, 1'b1, 1'b0);
      check("ce0 clr pre", 32'(fault_o), 32'd1);
      smp(6'b111_111, 1'b0, 1'b1);
      check("ce0 clr", 32'(fault_o), 32'd0);

      // Reset while holding a transitional word.
      smp(6'b111_110, 1'b1, 1'b0);
      do_reset();
      expect_reset_values("mid reset");

      smp(6'b010_010, 1'b1, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
